pwm_duty_ramp: RTL and testbench

//  Upstream stage of the PWM block: produces its duty_cycle input. Accepts a target

---
 rtl/pwm_duty_ramp.sv | 137 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews the PWM duty toward an accepted target by STEP every DIV
// PWM periods. Duty updates land only on period_tick edges, so the PWM counter
// wraps straight into the new duty.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   period_tick       1-cycle pulse on the last count of each PWM period
//   hold              freeze the ramp (ticks ignored, divider frozen)
//   abort             cancel an active ramp, keeping the current duty
//   tgt_valid/ready   target handshake; ready only while idle
//   tgt_data          target duty
//   duty_cycle        registered duty to the PWM
//   busy              ramp in progress
//   ramp_done         registered 1-cycle pulse when the target is reached
module pwm_duty_ramp #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DIV       = 4,
  parameter int unsigned INIT_DUTY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             period_tick,
  input  logic             hold,
  input  logic             abort,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             busy,
  output logic             ramp_done
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [EXT_W-1:0] STEP_X   = EXT_W'(STEP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WIDTH-1:0] INIT_X   = WIDTH'(INIT_DUTY);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;

  logic [EXT_W-1:0] up_diff;
  logic [EXT_W-1:0] down_diff;
  logic [WIDTH-1:0] step_val;

  // Next duty for one step, clamped at the target; distances use one spare bit
  // so neither direction can wrap.
  always_comb begin
    up_diff   = {1'b0, tgt_q} - {1'b0, duty_q};
    down_diff = {1'b0, duty_q} - {1'b0, tgt_q};
    step_val  = duty_q;
    if (state_q == RAMP_UP) begin
      step_val = (up_diff <= STEP_X) ? tgt_q : WIDTH'({1'b0, duty_q} + STEP_X);
    end else if (state_q == RAMP_DOWN) begin
      step_val = (down_diff <= STEP_X) ? tgt_q : WIDTH'({1'b0, duty_q} - STEP_X);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    div_d   = div_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d = tgt_data;
          div_d = '0;
          if (tgt_data > duty_q) begin
            state_d = RAMP_UP;
          end else if (tgt_data < duty_q) begin
            state_d = RAMP_DOWN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        // abort takes priority over a coincident step
        if (abort) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (period_tick && !hold) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            duty_d = step_val;
            if (step_val == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= INIT_X;
      tgt_q   <= INIT_X;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  // Handshake flags decode straight from the state register.
  assign tgt_ready  = (state_q == IDLE);
  assign busy       = ~tgt_ready;
  assign duty_cycle = duty_q;
  assign ramp_done  = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: four instances with different STEP/DIV share the
// stimulus; a monitor compares every duty change or ramp_done pulse of the
// selected instance against a queue of expected events.
module tb_pwm_duty_ramp;

  typedef struct packed {
    logic [7:0] duty;
    logic       done;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       period_tick;
  logic       hold;
  logic       abort;
  logic       tgt_valid;
  logic [7:0] tgt_data;

  logic       rdy_a, rdy_b, rdy_c, rdy_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;
  logic [7:0] duty_a, duty_b, duty_c, duty_d;

  logic       cur_rdy, cur_busy, cur_done;
  logic [7:0] cur_duty;

  int   sel;
  int   checks;
  int   failures;
  ev_t  sb[$];
  logic [7:0] prev_duty;

  pwm_duty_ramp #(.WIDTH(8), .STEP(1),  .DIV(4), .INIT_DUTY(0)) u_a (
    .clk(clk), .rst(rst), .period_tick(period_tick), .hold(hold), .abort(abort),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy_a),
    .duty_cycle(duty_a), .busy(busy_a), .ramp_done(done_a));
  pwm_duty_ramp #(.WIDTH(8), .STEP(16), .DIV(1), .INIT_DUTY(0)) u_b (
    .clk(clk), .rst(rst), .period_tick(period_tick), .hold(hold), .abort(abort),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy_b),
    .duty_cycle(duty_b), .busy(busy_b), .ramp_done(done_b));
  pwm_duty_ramp #(.WIDTH(8), .STEP(1),  .DIV(2), .INIT_DUTY(0)) u_c (
    .clk(clk), .rst(rst), .period_tick(period_tick), .hold(hold), .abort(abort),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy_c),
    .duty_cycle(duty_c), .busy(busy_c), .ramp_done(done_c));
  pwm_duty_ramp #(.WIDTH(8), .STEP(1),  .DIV(1), .INIT_DUTY(0)) u_d (
    .clk(clk), .rst(rst), .period_tick(period_tick), .hold(hold), .abort(abort),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy_d),
    .duty_cycle(duty_d), .busy(busy_d), .ramp_done(done_d));

  always_comb begin
    cur_rdy  = rdy_a;
    cur_busy = busy_a;
    cur_done = done_a;
    cur_duty = duty_a;
    case (sel)
      1: begin cur_rdy = rdy_b; cur_busy = busy_b; cur_done = done_b; cur_duty = duty_b; end
      2: begin cur_rdy = rdy_c; cur_busy = busy_c; cur_done = done_c; cur_duty = duty_c; end
      3: begin cur_rdy = rdy_d; cur_busy = busy_d; cur_done = done_d; cur_duty = duty_d; end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: any duty change or ramp_done pulse is an output event.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      prev_duty = cur_duty;
    end else begin
      if (cur_done || (cur_duty != prev_duty)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got duty=%0d done=%0d expected none",
                   cur_duty, cur_done);
        end else begin
          e = sb.pop_front();
          chk("event_duty", int'(cur_duty), int'(e.duty));
          chk("event_done", int'(cur_done), int'(e.done));
        end
      end
      prev_duty = cur_duty;
    end
  end

  task automatic do_reset(input int s);
    @(negedge clk);
    #2 rst = 1'b1;
    sel = s;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = d;
    @(negedge clk);
    tgt_valid = 1'b0;
    #1;
  endtask

  task automatic do_tick();
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic expect_ev(input logic [7:0] d, input logic dn);
    ev_t e;
    e.duty = d;
    e.done = dn;
    sb.push_back(e);
  endtask

  // The tick that must produce exactly this event.
  task automatic tick_step(input string name, input logic [7:0] d, input logic dn);
    expect_ev(d, dn);
    do_tick();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    checks = 0; failures = 0; sel = 0;
    rst = 1'b1; period_tick = 1'b0; hold = 1'b0; abort = 1'b0;
    tgt_valid = 1'b0; tgt_data = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // 1: reset values, then asynchronous reset pulse mid-ramp
    #1;
    chk("rst_duty", int'(cur_duty), 0);
    chk("rst_ready", int'(cur_rdy), 1);
    chk("rst_busy", int'(cur_busy), 0);
    chk("rst_done", int'(cur_done), 0);
    accept(8'd3);
    ticks(3);
    tick_step("pre_rst_step", 8'd1, 1'b0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_duty", int'(cur_duty), 0);
    chk("async_rst_ready", int'(cur_rdy), 1);
    chk("async_rst_busy", int'(cur_busy), 0);
    chk("async_rst_done", int'(cur_done), 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // 2: STEP=1 DIV=4, 0 -> 3
    accept(8'd3);
    chk("t2_ready_low", int'(cur_rdy), 0);
    chk("t2_busy_high", int'(cur_busy), 1);
    ticks(3);
    tick_step("t2_tick4", 8'd1, 1'b0);
    ticks(3);
    tick_step("t2_tick8", 8'd2, 1'b0);
    ticks(3);
    tick_step("t2_tick12", 8'd3, 1'b1);
    chk("t2_ready_back", int'(cur_rdy), 1);
    chk("t2_busy_low", int'(cur_busy), 0);
    @(negedge clk);
    #1 chk("t2_done_one_cycle", int'(cur_done), 0);
    ticks(2);  // ticks while idle must not move duty

    // 3: STEP=16 DIV=1, clamped up and down
    do_reset(1);
    accept(8'd40);
    tick_step("t3_up16", 8'd16, 1'b0);
    tick_step("t3_up32", 8'd32, 1'b0);
    tick_step("t3_up40", 8'd40, 1'b1);
    accept(8'd0);
    chk("t3_down_busy", int'(cur_busy), 1);
    tick_step("t3_dn24", 8'd24, 1'b0);
    tick_step("t3_dn8", 8'd8, 1'b0);
    tick_step("t3_dn0", 8'd0, 1'b1);

    // 4: hold freezes the divider mid-count
    do_reset(2);
    accept(8'd2);
    do_tick();
    hold = 1'b1;
    ticks(5);
    chk("t4_hold_duty", int'(cur_duty), 0);
    chk("t4_hold_busy", int'(cur_busy), 1);
    hold = 1'b0;
    tick_step("t4_release", 8'd1, 1'b0);
    do_tick();
    tick_step("t4_final", 8'd2, 1'b1);

    // 5: abort coincident with a step tick
    do_reset(3);
    accept(8'd1);
    @(negedge clk);
    period_tick = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
    abort = 1'b0;
    #1;
    chk("t5_abort_ready", int'(cur_rdy), 1);
    chk("t5_abort_duty", int'(cur_duty), 0);
    @(negedge clk);
    #1 chk("t5_no_done", int'(cur_done), 0);
    abort = 1'b1;
    accept(8'd1);
    abort = 1'b0;
    chk("t5_idle_abort_accept", int'(cur_rdy), 0);
    tick_step("t5_after_abort", 8'd1, 1'b1);

    // 6: equal target, then async reset during a long ramp
    do_reset(3);
    accept(8'd5);
    tick_step("t6_s1", 8'd1, 1'b0);
    tick_step("t6_s2", 8'd2, 1'b0);
    tick_step("t6_s3", 8'd3, 1'b0);
    tick_step("t6_s4", 8'd4, 1'b0);
    tick_step("t6_s5", 8'd5, 1'b1);
    expect_ev(8'd5, 1'b1);
    accept(8'd5);
    chk("t6_equal_done", sb.size(), 0);
    chk("t6_equal_ready", int'(cur_rdy), 1);
    accept(8'd200);
    tick_step("t6_s6", 8'd6, 1'b0);
    tick_step("t6_s7", 8'd7, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_duty", int'(cur_duty), 0);
    chk("t6_rst_ready", int'(cur_rdy), 1);
    chk("t6_rst_busy", int'(cur_busy), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    ticks(2);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
